// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster timing plus framebuffer read-out, pixel-doubled 256x240 image centred in the active area.
// Latency: fb_addr lags the raster counters by 1 pixel tick; hsync/vsync/blank/RGB lag them by 2 ticks, mutually aligned.
// Backpressure: none; the raster free-runs and fb_data must be valid 1 clk after fb_addr. Optional colour bars: VGA_SCANOUT_TESTPAT_EN.
`timescale 1ns/1ps

module vga_scanout #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int X_OFFSET   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [DATA_WIDTH-1:0] fb_data,
  input  logic                  test_mode,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic                  vblank,
  output logic                  frame_start,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [1:0]            vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int IMG_W   = 512;  // 256 framebuffer columns, each shown twice

  // Counters are at least 10 bits so the doubled-pixel address bits [8:1] always exist.
  localparam int HB = $clog2(H_TOTAL);
  localparam int VB = $clog2(V_TOTAL);
  localparam int MB = (HB > VB) ? HB : VB;
  localparam int CW = (MB > 10) ? MB : 10;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] WIN_BEG  = CW'(X_OFFSET);
  localparam logic [CW-1:0] WIN_END  = CW'(X_OFFSET + IMG_W);

  logic [DW-1:0]         div;
  logic                  tick;
  logic [CW-1:0]         h_cnt;
  logic [CW-1:0]         v_cnt;
  logic [CW-1:0]         h_rel;
  logic                  h_last;
  logic                  v_last;
  logic                  in_win;
  logic                  active;
  logic                  hs_n;
  logic                  vs_n;
  logic                  s1_win;
  logic                  s1_act;
  logic                  s1_hs;
  logic                  s1_vs;
  logic [DATA_WIDTH-1:0] pix;
  logic [DATA_WIDTH-1:0] pix_nxt;
  logic                  unused_bits;

  assign tick   = (div == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign h_rel  = h_cnt - WIN_BEG;

  // Raster decode for the current (undelayed) counter state.
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_win = (h_cnt >= WIN_BEG) && (h_cnt < WIN_END) && (v_cnt < V_ACT);
  assign hs_n   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign vblank = (v_cnt >= V_ACT);

  // Pixel-rate divider: tick marks the last clk of each pixel period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Horizontal/vertical raster counters, advancing once per pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // One-clk strobe on the tick that wraps the raster back to (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_last && v_last;
    end
  end

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic [2:0] s1_bar;

  function automatic logic [7:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 8'hFF;
      3'd1:    bar_colour = 8'hFC;
      3'd2:    bar_colour = 8'h1F;
      3'd3:    bar_colour = 8'h1C;
      3'd4:    bar_colour = 8'hE3;
      3'd5:    bar_colour = 8'hE0;
      3'd6:    bar_colour = 8'h03;
      default: bar_colour = 8'h00;
    endcase
  endfunction

  // Bar index travels with the stage-1 terms so the bars keep the same latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_bar <= '0;
    end else if (tick) begin
      s1_bar <= 3'(h_cnt / CW'(80));
    end
  end

  assign unused_bits = ^{h_rel[0], h_rel[CW-1:9], v_cnt[0], v_cnt[CW-1:9]};
`else
  assign unused_bits = ^{h_rel[0], h_rel[CW-1:9], v_cnt[0], v_cnt[CW-1:9], test_mode};
`endif

  // Stage 1: issue the framebuffer read and register the decode terms alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addr <= '0;
      s1_win  <= 1'b0;
      s1_act  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
    end else if (tick) begin
      fb_addr <= in_win ? ADDR_WIDTH'({v_cnt[8:1], h_rel[8:1]}) : '0;
      s1_win  <= in_win;
      s1_act  <= active;
      s1_hs   <= hs_n;
      s1_vs   <= vs_n;
    end
  end

  // Stage-2 pixel select: black outside the active area, borders black, bars override when enabled.
  always_comb begin
    pix_nxt = '0;
    if (s1_act) begin
      if (s1_win) begin
        pix_nxt = fb_data;
      end
`ifdef VGA_SCANOUT_TESTPAT_EN
      if (test_mode) begin
        pix_nxt = DATA_WIDTH'(bar_colour(s1_bar));
      end
`endif
    end
  end

  // Stage 2: register the visible outputs, all aligned to the same raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix   <= '0;
      blank <= 1'b1;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      pix   <= pix_nxt;
      blank <= !s1_act;
      hsync <= s1_hs;
      vsync <= s1_vs;
    end
  end

  assign vga_r = pix[7:5];
  assign vga_g = pix[4:2];
  assign vga_b = pix[1:0];

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Raster scan-out stage downstream of the dual-port framebuffer. Drives the framebuffer read port (addr_b/q_b) and generates 640x480@60 VGA timing.
- Framebuffer is 256x256 bytes of 8-bit RRRGGGBB pixels. Rows 0..239 and all 256 columns are displayed, pixel-doubled to 512x480 and centred horizontally with black borders.
- Provides a frame_start strobe and a vblank level so game logic can schedule port-A writes.

Parameters:
- DATA_WIDTH, 8, framebuffer pixel width (RRRGGGBB)
- ADDR_WIDTH, 16, framebuffer address width {row[7:0], col[7:0]}
- CLK_DIV, 2, clk cycles per pixel (50 MHz clk gives a 25 MHz pixel rate); minimum 2
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48 (horizontal timing in pixels)
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33 (vertical timing in lines)
- X_OFFSET, 64, first active column of the 512-pixel image window

Ports:
- clk  in  1  system clock, same clock as the framebuffer
- rst  in  1  synchronous, active-high reset
- fb_addr  out  ADDR_WIDTH  framebuffer port-B read address
- fb_data  in  DATA_WIDTH  framebuffer port-B read data; valid 1 clk after fb_addr
- test_mode  in  1  colour-bar select (see Optional Feature)
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank  out  1  high outside the 640x480 active area
- vblank  out  1  high while the current line is >= V_ACTIVE (undelayed counter domain)
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)
- vga_r  out  3  red = pixel[7:5]
- vga_g  out  3  green = pixel[4:2]
- vga_b  out  2  blue = pixel[1:0]

Behaviour:
- Decided: a single clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - all counters 0, fb_addr 0
  - hsync 1, vsync 1, blank 1, vblank 0, frame_start 0
  - vga_r, vga_g, vga_b all 0
- Reset mid-frame: the raster restarts at (0,0) on the first clk after rst deasserts.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick = (div == CLK_DIV-1).
  - All state below advances only on tick, except frame_start and vblank.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - v_cnt runs 0..V_TOTAL-1 (525) and increments when h_cnt wraps.
  - Both wrap to 0 together at (H_TOTAL-1, V_TOTAL-1).
- Stage 1 (tick after counter state C):
  - in window: fb_addr = {v_cnt[8:1], (h_cnt - X_OFFSET)[8:1]}
  - out of window: fb_addr = 0
  - in window means h_cnt in [X_OFFSET, X_OFFSET+512) and v_cnt < 480
  - The in-window, active, hsync and vsync terms for C are registered alongside fb_addr.
- Stage 2 (next tick):
  - fb_data is sampled; this is at least 1 clk after fb_addr changed.
  - RGB = fb_data if in-window, else 0.
  - blank = !active; when blank is high RGB is forced to 0.
- Net latency: hsync, vsync, blank and RGB lag counter state by exactly 2 pixel ticks, mutually aligned.
- Sync decode:
  - hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656, 752)
  - vsync low for v_cnt in [490, 492)
- Each pixel column/row pair maps to one byte; framebuffer rows 240..255 are never read.
- frame_start is high for exactly one clk, on the tick where the counters become (0,0).
- fb_addr is held stable between ticks.

Optional Feature:
- Macro: VGA_SCANOUT_TESTPAT_EN.
- Defined: when test_mode=1, stage 2 replaces fb_data with 8 vertical colour bars across the 640 active pixels.
  - Bar index = h_cnt[9:0]/80.
  - Colours, in order: FF, FC, 1F, 1C, E3, E0, 03, 00.
  - Timing and latency are unchanged; fb_addr still toggles.
- Undefined: test_mode is ignored and the output is always framebuffer data.

Test Plan:
- Reset held 5 clk then released -> hsync=vsync=1, RGB=0, blank=1 during reset; frame_start pulse once V_TOTAL*H_TOTAL*CLK_DIV = 840000 clk later.
- Free run 2 frames -> hsync low 96 ticks per 800-tick line; vsync low 2 lines (1600 ticks) per 525-line frame; edges at the counts given above.
- Preload framebuffer[addr 0x0000]=0xE0 and [0x0001]=0x1C -> active pixel columns 64,65 red (r=7,g=0,b=0); 66,67 green (r=0,g=7,b=0); both on lines 0 and 1.
- Address check -> framebuffer [0xEFFF]=0x03 appears at columns 574..575, lines 478..479; borders (columns 0..63 and 576..639) always RGB=0.
- Assert rst at line 200 for 1 clk -> next clk counters at (0,0), outputs at reset values, frame timing restarts.
- With VGA_SCANOUT_TESTPAT_EN and test_mode=1 -> pixel 0 = FF, pixel 80 = FC, pixel 639 = 00; without the macro -> framebuffer data is shown.
